// File: rtl/eps_sched.sv
`default_nettype none
// ============================================================================
// Module   : eps_sched
// Purpose  : Round-robin scheduler that shares one epsilon PRNG between NREQ
//            sampling units. It sequences PRNG seed loads (power-up and
//            on-demand reseeds) and, once the PRNG output is trusted, grants
//            at most one requester per cycle. Each grant carries the current
//            16-bit epsilon and the index of the granted requester.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            req[NREQ]          - per-requester request, held until granted
//            gnt[NREQ]          - one-hot one-cycle grant pulse
//            eps_out[16]        - epsilon delivered with the grant
//            eps_valid          - high in the same cycle as any gnt bit
//            eps_id[IDW]        - index of the granted requester
//            reseed_req         - single-cycle reseed request (RUN only)
//            reseed_seed[5]     - seed captured with reseed_req
//            busy               - high while reseeding / settling
//            grant_count[16]    - wrapping count of grants since reset
//            prng_rst           - PRNG reset / seed-load strobe
//            prng_seed[5]       - PRNG seed value
//            prng_data[16]      - PRNG random output
// Option   : EPS_SIGN_EN - when defined, every second grant delivers the
//            two's-complement negation of prng_data (zero-mean epsilon).
// Revision : 1.0 - initial release
// ============================================================================
module eps_sched #(
    parameter int         NREQ         = 4,
    parameter int         IDW          = $clog2(NREQ),
    parameter logic [4:0] SEED_DEFAULT = 5'd3,
    parameter int         SETTLE       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     eps_out,
    output logic            eps_valid,
    output logic [IDW-1:0]  eps_id,
    input  logic            reseed_req,
    input  logic [4:0]      reseed_seed,
    output logic            busy,
    output logic [15:0]     grant_count,
    output logic            prng_rst,
    output logic [4:0]      prng_seed,
    input  logic [15:0]     prng_data
);

    localparam int                c_CW         = $clog2(SETTLE + 1);
    localparam logic [c_CW-1:0]   c_SETTLE_CNT = c_CW'(SETTLE);
    localparam logic [c_CW-1:0]   c_CNT_ONE    = c_CW'(1);

    typedef enum logic [1:0] {
        ST_RESEED = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [IDW-1:0]    r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic              r_valid;
    logic [15:0]       r_eps;
    logic [IDW-1:0]    r_id;
    logic [15:0]       r_count;
    logic [4:0]        r_seed;

    logic [NREQ-1:0]   w_elig;
    logic              w_found;
    logic [IDW-1:0]    w_win;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_next_ptr;
    logic [NREQ-1:0]   w_onehot;
    logic [15:0]       w_eps;

    // Last cycle's winner is masked so a lone requester cannot monopolise
    // consecutive PRNG values and every grant sees a fresh PRNG cycle.
    // The search walks upward from r_ptr with a wrap at NREQ-1.
    always_comb begin
        w_elig  = req & ~r_gnt;
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (!w_found && w_elig[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDW-1:0];
            end
        end
    end

    assign w_next_ptr = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
    assign w_onehot   = NREQ'(1) << w_win;

`ifdef EPS_SIGN_EN
    logic r_tog;
    // Negation of 0 is 0, so the zero table entry stays unsigned-neutral.
    assign w_eps = r_tog ? (16'd0 - prng_data) : prng_data;
`else
    assign w_eps = prng_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESEED;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_eps   <= '0;
            r_id    <= '0;
            r_count <= '0;
            r_seed  <= SEED_DEFAULT;
`ifdef EPS_SIGN_EN
            r_tog   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_RESEED: begin
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                    r_cnt   <= c_SETTLE_CNT;
                    r_state <= ST_SETTLE;
`ifdef EPS_SIGN_EN
                    r_tog   <= 1'b0;
`endif
                end
                ST_SETTLE: begin
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                    r_cnt   <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (reseed_req) begin
                        // Reseed wins over any pending request this cycle.
                        r_seed  <= reseed_seed;
                        r_state <= ST_RESEED;
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                    end else if (w_found) begin
                        r_gnt   <= w_onehot;
                        r_valid <= 1'b1;
                        r_id    <= w_win;
                        r_eps   <= w_eps;
                        r_ptr   <= w_next_ptr;
                        r_count <= r_count + 16'd1;
`ifdef EPS_SIGN_EN
                        r_tog   <= ~r_tog;
`endif
                    end else begin
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_RESEED;
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign eps_valid   = r_valid;
    assign eps_out     = r_eps;
    assign eps_id      = r_id;
    assign grant_count = r_count;
    assign prng_seed   = r_seed;
    assign busy        = (r_state != ST_RUN);
    // Seed load is asserted during reset itself as well as in RESEED.
    assign prng_rst    = rst || (r_state == ST_RESEED);

endmodule
`default_nettype wire

// File: tb/tb_eps_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_eps_sched
// Purpose  : Self-checking bench for eps_sched: directed scenarios plus a
//            randomized run compared against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eps_sched;

    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int SETTLE = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [15:0]     eps_out;
    logic            eps_valid;
    logic [IDW-1:0]  eps_id;
    logic            reseed_req;
    logic [4:0]      reseed_seed;
    logic            busy;
    logic [15:0]     grant_count;
    logic            prng_rst;
    logic [4:0]      prng_seed;
    logic [15:0]     prng_data;

    int n_cmp = 0;
    int n_err = 0;

    eps_sched #(.NREQ(NREQ), .IDW(IDW), .SEED_DEFAULT(5'd3), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .eps_out(eps_out),
        .eps_valid(eps_valid), .eps_id(eps_id), .reseed_req(reseed_req),
        .reseed_seed(reseed_seed), .busy(busy), .grant_count(grant_count),
        .prng_rst(prng_rst), .prng_seed(prng_seed), .prng_data(prng_data)
    );

    always #5 clk = ~clk;

    // Reference model. m_k counts cycles since a seed load began:
    // 0 = seed load, 1..SETTLE = settling, above that = running.
    int          m_k;
    int          m_ptr;
    logic [3:0]  m_gnt;
    logic        m_valid;
    logic [15:0] m_eps;
    int          m_id;
    logic [15:0] m_cnt;
    logic [4:0]  m_seed;
    bit          m_tog;

    task automatic model_edge();
        logic [3:0] elig;
        int win;
        if (rst) begin
            m_k = 0; m_ptr = 0; m_gnt = 0; m_valid = 0; m_eps = 0; m_id = 0;
            m_cnt = 0; m_seed = 5'd3; m_tog = 0;
        end else if (m_k <= SETTLE) begin
            if (m_k == 0) m_tog = 0;
            m_k++;
            m_gnt = 0; m_valid = 0;
        end else if (reseed_req) begin
            m_seed = reseed_seed; m_k = 0; m_gnt = 0; m_valid = 0; m_tog = 0;
        end else begin
            elig = req & ~m_gnt;
            win = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (win < 0 && elig[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
            end
            if (win >= 0) begin
                m_gnt = 4'(1 << win);
                m_valid = 1;
                m_id = win;
`ifdef EPS_SIGN_EN
                m_eps = m_tog ? 16'(-int'(prng_data)) : prng_data;
`else
                m_eps = prng_data;
`endif
                m_tog = !m_tog;
                m_ptr = (win + 1) % NREQ;
                m_cnt = m_cnt + 16'd1;
            end else begin
                m_gnt = 0; m_valid = 0;
            end
        end
    endtask

    // One clock: the model consumes this cycle's inputs, then the bench
    // lands 1 time unit after the edge where outputs are stable.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 0; reseed_req = 0; reseed_seed = 0; prng_data = 0;
    endtask

    // Reset, then release: on return the DUT is in power-up cycle 0.
    task automatic reset_release();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_cmp++; if (eps_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", eps_valid); end
        n_cmp++; if (eps_out !== 16'h0) begin n_err++; $display("FAIL reset_eps got=%h exp=0000", eps_out); end
        n_cmp++; if (eps_id !== 2'd0) begin n_err++; $display("FAIL reset_id got=%0d exp=0", eps_id); end
        n_cmp++; if (grant_count !== 16'h0) begin n_err++; $display("FAIL reset_count got=%h exp=0000", grant_count); end
        n_cmp++; if (prng_rst !== 1'b1) begin n_err++; $display("FAIL reset_prng_rst got=%b exp=1", prng_rst); end
        n_cmp++; if (prng_seed !== 5'd3) begin n_err++; $display("FAIL reset_seed got=%0d exp=3", prng_seed); end
    endtask

    // Power-up timing and single-requester behaviour.
    task automatic test_powerup_single();
        idle_inputs();
        reset_release();
        req = 4'b0010;
        // cycle 0
        n_cmp++; if (prng_rst !== 1'b1 || prng_seed !== 5'd3) begin n_err++; $display("FAIL pwr_c0_prng got=%b/%0d exp=1/3", prng_rst, prng_seed); end
        for (int c = 0; c <= 2; c++) begin
            n_cmp++; if (busy !== 1'b1 || gnt !== 4'b0) begin n_err++; $display("FAIL pwr_busy c%0d got=%b/%b exp=1/0000", c, busy, gnt); end
            step();
        end
        // cycle 3: running, decision cycle
        n_cmp++; if (busy !== 1'b0 || prng_rst !== 1'b0) begin n_err++; $display("FAIL pwr_c3 busy/prng_rst got=%b/%b exp=0/0", busy, prng_rst); end
        prng_data = 16'h0071;
        step();
        prng_data = 16'h1234;
        n_cmp++; if (gnt !== 4'b0010 || eps_id !== 2'd1 || eps_out !== 16'h0071 || eps_valid !== 1'b1)
            begin n_err++; $display("FAIL single_grant got=%b/%0d/%h/%b exp=0010/1/0071/1", gnt, eps_id, eps_out, eps_valid); end
        step();
        n_cmp++; if (gnt !== 4'b0 || eps_valid !== 1'b0 || eps_out !== 16'h0071)
            begin n_err++; $display("FAIL single_gap got=%b/%b/%h exp=0000/0/0071", gnt, eps_valid, eps_out); end
        step();
        n_cmp++; if (gnt !== 4'b0010 || eps_out !== 16'h1234 || grant_count !== 16'd2)
            begin n_err++; $display("FAIL single_second got=%b/%h/%0d exp=0010/1234/2", gnt, eps_out, grant_count); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g;
        idle_inputs();
        reset_release();
        req = 4'b1111;
        for (int c = 0; c < 4; c++) step();   // land in cycle 4
        for (int g = 0; g < 8; g++) begin
            exp_g = 4'b0001 << (g % 4);
            prng_data = 16'(g * 7 + 1);
            n_cmp++; if (gnt !== exp_g) begin n_err++; $display("FAIL fair_seq g%0d got=%b exp=%b", g, gnt, exp_g); end
            if (g < 7) step();
        end
        n_cmp++; if (grant_count !== 16'd8) begin n_err++; $display("FAIL fair_count got=%0d exp=8", grant_count); end
    endtask

    task automatic test_reseed();
        idle_inputs();
        reset_release();
        req = 4'b0001;
        for (int c = 0; c < 6; c++) step();
        // cycle t
        reseed_req = 1'b1; reseed_seed = 5'd11;
        step();
        reseed_req = 1'b0; reseed_seed = 5'd0;
        n_cmp++; if (prng_rst !== 1'b1 || prng_seed !== 5'd11) begin n_err++; $display("FAIL reseed_t1 got=%b/%0d exp=1/11", prng_rst, prng_seed); end
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reseed_nogrant t+%0d got=%b exp=0000", c, gnt); end
            n_cmp++; if (busy !== (c <= 3)) begin n_err++; $display("FAIL reseed_busy t+%0d got=%b exp=%b", c, busy, c <= 3); end
            // A reseed while settling must be ignored.
            if (c == 2) begin reseed_req = 1'b1; reseed_seed = 5'd7; end
            else begin reseed_req = 1'b0; reseed_seed = 5'd0; end
            step();
        end
        n_cmp++; if (gnt !== 4'b0001 || prng_seed !== 5'd11) begin n_err++; $display("FAIL reseed_t5 got=%b/%0d exp=0001/11", gnt, prng_seed); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        idle_inputs();
        reset_release();
        req = 4'b1111;
        prng_data = 16'hBEEF;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (gnt === 4'b0100) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL mid_wait got=timeout exp=gnt 0100"); end
        rst = 1'b1;
        step();
        n_cmp++; if (gnt !== 4'b0 || eps_out !== 16'h0 || grant_count !== 16'h0 || busy !== 1'b1 || prng_rst !== 1'b1)
            begin n_err++; $display("FAIL mid_reset got=%b/%h/%h/%b/%b exp=0000/0000/0000/1/1", gnt, eps_out, grant_count, busy, prng_rst); end
        rst = 1'b0;
    endtask

    task automatic test_sign();
        idle_inputs();
        reset_release();
        req = 4'b0011;
        prng_data = 16'h0155;
        for (int c = 0; c < 4; c++) step();
        n_cmp++; if (eps_out !== 16'h0155) begin n_err++; $display("FAIL sign_first got=%h exp=0155", eps_out); end
        step();
`ifdef EPS_SIGN_EN
        n_cmp++; if (eps_out !== 16'hFEAB) begin n_err++; $display("FAIL sign_second got=%h exp=FEAB", eps_out); end
`else
        n_cmp++; if (eps_out !== 16'h0155) begin n_err++; $display("FAIL sign_second got=%h exp=0155", eps_out); end
`endif
    endtask

    task automatic test_random();
        int errs_here = 0;
        idle_inputs();
        reset_release();
        for (int c = 0; c < 3000; c++) begin
            n_cmp++;
            if (gnt !== m_gnt || eps_valid !== m_valid || eps_out !== m_eps ||
                eps_id !== 2'(m_id) || grant_count !== m_cnt || prng_seed !== m_seed ||
                busy !== (m_k <= SETTLE) || prng_rst !== (rst || m_k == 0)) begin
                n_err++;
                if (errs_here++ < 10)
                    $display("FAIL rand c%0d got gnt=%b v=%b eps=%h id=%0d cnt=%h seed=%0d busy=%b prst=%b exp gnt=%b v=%b eps=%h id=%0d cnt=%h seed=%0d busy=%b prst=%b",
                             c, gnt, eps_valid, eps_out, eps_id, grant_count, prng_seed, busy, prng_rst,
                             m_gnt, m_valid, m_eps, m_id, m_cnt, m_seed, (m_k <= SETTLE), (rst || m_k == 0));
            end
            req         = 4'($urandom);
            prng_data   = 16'($urandom);
            reseed_req  = ($urandom_range(0, 19) == 0);
            reseed_seed = 5'($urandom);
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        idle_inputs();
        reset_release();
        req = 4'b1111;
        for (int c = 0; c < 3 + 65535; c++) step();
        n_cmp++; if (grant_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max got=%h exp=FFFF", grant_count); end
        step();
        n_cmp++; if (grant_count !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got=%h exp=0000", grant_count); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_k = 0; m_ptr = 0; m_gnt = 0; m_valid = 0; m_eps = 0; m_id = 0;
        m_cnt = 0; m_seed = 5'd3; m_tog = 0;
        #1;
        test_reset();
        test_powerup_single();
        test_fairness();
        test_reseed();
        test_reset_mid();
        test_sign();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
